// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide, combinational-read data memory.
// Sub-word stores use read-modify-write; bad requests are answered with resp_err and never touch memory.
module load_store_unit #(
   parameter int unsigned ADDR_LIMIT = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        dm_MemRead,
   output logic        dm_MemWrite,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_write_data,
   input  logic [31:0] dm_read_data
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_RMW_RD = 3'd2,
      S_WRITE  = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   state_t      state_q;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [31:0] resp_rdata_q;

   function automatic logic req_error(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      logic err;
      case (f3)
         3'b000:  err = 1'b0;
         3'b001:  err = addr[0];
         3'b010:  err = (addr[1:0] != 2'b00);
         3'b100:  err = we;
         3'b101:  err = we | addr[0];
         default: err = 1'b1;
      endcase
      return err | (addr >= ADDR_LIMIT);
   endfunction

   function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b010:  r = word;
         3'b100:  r = {24'd0, b};
         3'b101:  r = {16'd0, h};
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // Replace the addressed byte/half of the old word with the low store data.
   function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] old, input logic [31:0] wd);
      logic [31:0] m;
      m = old;
      case (f3)
         3'b000: begin
            case (lane)
               2'd0:    m[7:0]   = wd[7:0];
               2'd1:    m[15:8]  = wd[7:0];
               2'd2:    m[23:16] = wd[7:0];
               default: m[31:24] = wd[7:0];
            endcase
         end
         3'b001: begin
            if (lane[1]) m[31:16] = wd[15:0];
            else         m[15:0]  = wd[15:0];
         end
         default: m = wd;
      endcase
      return m;
   endfunction

   // Request FSM with latched request fields and registered response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         funct3_q     <= 3'd0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               resp_valid_q <= 1'b0;
               if (req_valid) begin
                  we_q     <= req_we;
                  funct3_q <= req_funct3;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  if (req_error(req_we, req_funct3, req_addr)) begin
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= 32'd0;
                     state_q      <= S_RESP;
                  end else if (!req_we) begin
                     state_q <= S_LOAD;
                  end else if (req_funct3 == 3'b010) begin
                     state_q <= S_WRITE;
                  end else begin
                     state_q <= S_RMW_RD;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_LOAD: begin
               resp_rdata_q <= load_extract(funct3_q, addr_q[1:0], dm_read_data);
               resp_err_q   <= 1'b0;
               resp_valid_q <= 1'b1;
               state_q      <= S_RESP;
            end
            S_RMW_RD: begin
               wdata_q <= store_merge(funct3_q, addr_q[1:0], dm_read_data, wdata_q);
               state_q <= S_WRITE;
            end
            S_WRITE: begin
               resp_rdata_q <= 32'd0;
               resp_err_q   <= 1'b0;
               resp_valid_q <= 1'b1;
               state_q      <= S_RESP;
            end
            S_RESP: begin
               resp_valid_q <= 1'b0;
               state_q      <= S_IDLE;
            end
            default: begin
               resp_valid_q <= 1'b0;
               state_q      <= S_IDLE;
            end
         endcase
      end
   end

   // Memory strobes decoded from state so they vanish the instant reset asserts.
   always_comb begin
      dm_MemRead    = 1'b0;
      dm_MemWrite   = 1'b0;
      dm_addr       = 32'd0;
      dm_write_data = 32'd0;
      case (state_q)
         S_LOAD, S_RMW_RD: begin
            dm_MemRead = 1'b1;
            dm_addr    = {addr_q[31:2], 2'b00};
         end
         S_WRITE: begin
            dm_MemWrite   = 1'b1;
            dm_addr       = {addr_q[31:2], 2'b00};
            dm_write_data = wdata_q;
         end
         default: begin
            dm_MemRead  = 1'b0;
            dm_MemWrite = 1'b0;
         end
      endcase
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;

   // we_q is kept for debug visibility of the accepted request.
   logic unused_we_s;
   assign unused_we_s = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory behind it.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        dm_MemRead, dm_MemWrite;
   logic [31:0] dm_addr, dm_write_data, dm_read_data;

   logic [31:0] mem [0:255];
   logic        mem_init;
   logic [32:0] exp_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_resp   = 0;
   int          rd_cycles = 0;
   int          wr_cycles = 0;

   load_store_unit #(.ADDR_LIMIT(32'd1024)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .dm_MemRead(dm_MemRead), .dm_MemWrite(dm_MemWrite), .dm_addr(dm_addr),
      .dm_write_data(dm_write_data), .dm_read_data(dm_read_data)
   );

   always #5 clk = ~clk;

   // Word memory: synchronous write, combinational read.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
         mem[16] <= 32'h8899AABB;
      end else if (dm_MemWrite) begin
         mem[dm_addr[9:2]] <= dm_write_data;
      end
   end
   assign dm_read_data = dm_MemRead ? mem[dm_addr[9:2]] : 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every response and watches memory strobes.
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (dm_MemRead)  rd_cycles++;
         if (dm_MemWrite) wr_cycles++;
         if (dm_MemRead || dm_MemWrite) begin
            chk("rd_wr_exclusive", {31'd0, dm_MemRead & dm_MemWrite}, 32'd0);
            chk("dm_addr_aligned", {30'd0, dm_addr[1:0]}, 32'd0);
         end
         if (resp_valid) begin
            n_resp++;
            if (exp_q.size() == 0) begin
               chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("resp_err", {31'd0, resp_err}, {31'd0, e[32]});
               chk("resp_rdata", resp_rdata, e[31:0]);
            end
         end
      end
   end

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd,
                        input logic drop);
      int n;
      exp_q.push_back({exp_err, exp_rd});
      @(negedge clk);
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      if (drop) req_valid = 1'b0;
   endtask

   // Counts negedges after the accept edge until the response count reaches target.
   task automatic wait_resp(input string name, input int target, input int exp_lat);
      int cnt;
      cnt = 0;
      while (n_resp < target && cnt < 20) begin
         @(negedge clk);
         #1;
         cnt++;
      end
      chk(name, cnt, exp_lat);
   endtask

   task automatic single(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic exp_err,
                         input logic [31:0] exp_rd, input int lat, input int exp_rd_c,
                         input int exp_wr_c);
      int r0, w0, t;
      r0 = rd_cycles; w0 = wr_cycles; t = n_resp + 1;
      issue(we, f3, addr, wd, exp_err, exp_rd, 1'b1);
      wait_resp({name, "_latency"}, t, lat);
      chk({name, "_rd_cycles"}, rd_cycles - r0, exp_rd_c);
      chk({name, "_wr_cycles"}, wr_cycles - w0, exp_wr_c);
   endtask

   initial begin
      int t, w0;
      rst = 1'b1; mem_init = 1'b1; req_valid = 1'b0; req_we = 1'b0;
      req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1; mem_init = 1'b0;
      @(negedge clk);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_dm_strobes", {30'd0, dm_MemRead, dm_MemWrite}, 32'd0);
      chk("rst_dm_addr", dm_addr, 32'd0);
      chk("rst_dm_wdata", dm_write_data, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", {31'd0, req_ready}, 32'd1);

      // Loads from Mem[0x40] = 0x8899AABB
      single("lw40",  1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'h8899AABB, 2, 1, 0);
      single("lb43",  1'b0, 3'b000, 32'h43, 32'h0, 1'b0, 32'hFFFFFF88, 2, 1, 0);
      single("lbu43", 1'b0, 3'b100, 32'h43, 32'h0, 1'b0, 32'h00000088, 2, 1, 0);
      single("lh42",  1'b0, 3'b001, 32'h42, 32'h0, 1'b0, 32'hFFFF8899, 2, 1, 0);
      single("lhu40", 1'b0, 3'b101, 32'h40, 32'h0, 1'b0, 32'h0000AABB, 2, 1, 0);

      // Stores
      single("sb41", 1'b1, 3'b000, 32'h41, 32'h12345677, 1'b0, 32'h0, 3, 1, 1);
      chk("sb41_mem", mem[16], 32'h889977BB);
      single("sh42", 1'b1, 3'b001, 32'h42, 32'h0000CAFE, 1'b0, 32'h0, 3, 1, 1);
      chk("sh42_mem", mem[16], 32'hCAFE77BB);
      single("sw44", 1'b1, 3'b010, 32'h44, 32'hDEADBEEF, 1'b0, 32'h0, 2, 0, 1);
      chk("sw44_mem", mem[17], 32'hDEADBEEF);
      chk("sw44_neighbour", mem[16], 32'hCAFE77BB);

      // Rejected requests
      single("err_lw42",  1'b0, 3'b010, 32'h42,  32'h0, 1'b1, 32'h0, 1, 0, 0);
      single("err_sh43",  1'b1, 3'b001, 32'h43,  32'h0, 1'b1, 32'h0, 1, 0, 0);
      single("err_f3011", 1'b0, 3'b011, 32'h40,  32'h0, 1'b1, 32'h0, 1, 0, 0);
      single("err_sb400", 1'b1, 3'b000, 32'h400, 32'h0, 1'b1, 32'h0, 1, 0, 0);
      single("err_sbu",   1'b1, 3'b100, 32'h40,  32'h0, 1'b1, 32'h0, 1, 0, 0);
      chk("err_mem_intact", mem[16], 32'hCAFE77BB);

      // Reset during RMW_RD: no write, no response
      w0 = wr_cycles; t = n_resp;
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h40; req_wdata = 32'h55; req_valid = 1'b1;
      @(posedge clk);
      #1; req_valid = 1'b0;
      @(negedge clk);
      chk("rmw_rd_reading", {31'd0, dm_MemRead}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_strobes", {30'd0, dm_MemRead, dm_MemWrite}, 32'd0);
      chk("rst_mid_idle", {31'd0, req_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_mid_no_write", wr_cycles - w0, 32'd0);
      chk("rst_mid_no_resp", n_resp - t, 32'd0);
      chk("rst_mid_mem", mem[16], 32'hCAFE77BB);

      // Back-to-back with req_valid held high
      t = n_resp;
      issue(1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'hCAFE77BB, 1'b0);
      @(negedge clk);
      chk("b2b_busy_ready", {31'd0, req_ready}, 32'd0);
      issue(1'b0, 3'b100, 32'h41, 32'h0, 1'b0, 32'h00000077, 1'b0);
      @(negedge clk);
      chk("b2b_busy_ready2", {31'd0, req_ready}, 32'd0);
      issue(1'b0, 3'b001, 32'h42, 32'h0, 1'b0, 32'hFFFFCAFE, 1'b1);
      repeat (6) @(negedge clk);
      #1;
      chk("b2b_resp_count", n_resp - t, 32'd3);
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
